// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// FETCH_EXC_TAG_EN adds the per-entry exception flags to fetch_entry_t.
package instr_fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
`ifdef FETCH_EXC_TAG_EN
        logic        miss;
        logic        illegal;
        logic        invalid;
`endif
    } fetch_entry_t;

    typedef enum logic [0:0] {
        DS_IDLE = 1'b0,
        DS_DROP = 1'b1
    } drop_state_e;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus: memory request/response side plus the decode-facing head entry.
// The master modport is the fetch queue; the slave modport is its environment.
interface instr_fetch_queue_if;
    logic        im_req;
    logic [31:0] im_pc;
    logic        uncache_inst;
    logic        icache_stall;
    logic        inst_sram_data_ok;
    logic [31:0] I_icache_rdata;
    logic [31:0] Instr_axi_Inter;
    logic        inst_exp_miss;
    logic        inst_exp_illegal;
    logic        inst_exp_invalid;
    logic        D_redirect;
    logic [31:0] D_NewPC_Pass;
    logic        exp_flush;
    logic [31:0] exp_pc;
    logic        D_stall_Pass;
    logic        dm_stall;
    logic        I_valid;
    logic [31:0] I_PC;
    logic [31:0] I_Instr;
    logic        I_inst_miss;
    logic        I_inst_illegal;
    logic        I_inst_invalid;
    logic        I_nextNotReady;

    modport master (
        output im_req, im_pc, I_valid, I_PC, I_Instr,
               I_inst_miss, I_inst_illegal, I_inst_invalid, I_nextNotReady,
        input  uncache_inst, icache_stall, inst_sram_data_ok, I_icache_rdata,
               Instr_axi_Inter, inst_exp_miss, inst_exp_illegal, inst_exp_invalid,
               D_redirect, D_NewPC_Pass, exp_flush, exp_pc, D_stall_Pass, dm_stall
    );

    modport slave (
        input  im_req, im_pc, I_valid, I_PC, I_Instr,
               I_inst_miss, I_inst_illegal, I_inst_invalid, I_nextNotReady,
        output uncache_inst, icache_stall, inst_sram_data_ok, I_icache_rdata,
               Instr_axi_Inter, inst_exp_miss, inst_exp_illegal, inst_exp_invalid,
               D_redirect, D_NewPC_Pass, exp_flush, exp_pc, D_stall_Pass, dm_stall
    );
endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// DEPTH-entry circular FIFO of fetch entries with synchronous flush.
// Head is presented directly from storage; reads as zero when empty.
module instr_fetch_queue_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  fetch_entry_t  din,
    output fetch_entry_t  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    // Overflow/underflow requests are dropped rather than corrupting pointers.
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign dout      = empty ? fetch_entry_t'(0) : mem_r[rd_ptr_r];

    // Pointer, occupancy and storage update; flush outranks push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= fetch_entry_t'(0);
            end
        end else if (flush) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: sequential prefetch into a DEPTH-entry queue with redirect/flush handling.
// Define FETCH_EXC_TAG_EN to carry TLB/address exception flags with each entry.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic                  Clk,
    input logic                  Clr_n,
    instr_fetch_queue_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    drop_state_e   state_r;
    drop_state_e   state_s;
    logic [31:0]   pc_r;
    logic [31:0]   pc_s;
    logic          run_r;
    logic          unc_pend_r;
    logic          unc_pend_s;
    logic          flush_s;
    logic          req_s;
    logic          rsp_s;
    logic          pop_s;
    logic [CW-1:0] count_s;
    logic          full_s;
    logic          empty_s;
    fetch_entry_t  push_entry_s;
    fetch_entry_t  head_s;

    assign flush_s    = bus.exp_flush | bus.D_redirect;
    // run_r holds requests off for the first cycle after reset release.
    assign req_s      = run_r & (count_s < DEPTH_C) & (state_r == DS_IDLE) & ~flush_s;
    assign rsp_s      = req_s & (bus.uncache_inst ? bus.inst_sram_data_ok : ~bus.icache_stall);
    assign unc_pend_s = req_s & bus.uncache_inst & ~bus.inst_sram_data_ok;
    assign pop_s      = ~empty_s & ~bus.D_stall_Pass & ~bus.dm_stall;

    // Build the entry captured from the active response path.
    always_comb begin
        push_entry_s       = fetch_entry_t'(0);
        push_entry_s.pc    = pc_r;
        push_entry_s.instr = bus.uncache_inst ? bus.Instr_axi_Inter : bus.I_icache_rdata;
`ifdef FETCH_EXC_TAG_EN
        push_entry_s.miss    = bus.inst_exp_miss;
        push_entry_s.illegal = bus.inst_exp_illegal;
        push_entry_s.invalid = bus.inst_exp_invalid;
        if (bus.inst_exp_miss | bus.inst_exp_illegal | bus.inst_exp_invalid) begin
            push_entry_s.instr = 32'h0000_0000;
        end else begin
            push_entry_s.instr = push_entry_s.instr;
        end
`endif
    end

    instr_fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Clr_n),
        .flush (flush_s),
        .push  (rsp_s),
        .pop   (pop_s),
        .din   (push_entry_s),
        .dout  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Next fetch PC: exception vector beats redirect beats sequential advance.
    always_comb begin
        pc_s = pc_r;
        if (bus.exp_flush) begin
            pc_s = bus.exp_pc;
        end else if (bus.D_redirect) begin
            pc_s = bus.D_NewPC_Pass;
        end else if (rsp_s) begin
            pc_s = pc_r + 32'd4;
        end else begin
            pc_s = pc_r;
        end
    end

    // Drop FSM: an uncached request cut off by a flush must have its late data swallowed.
    always_comb begin
        state_s = state_r;
        case (state_r)
            DS_IDLE: begin
                if (flush_s && unc_pend_r && !bus.inst_sram_data_ok) begin
                    state_s = DS_DROP;
                end else begin
                    state_s = DS_IDLE;
                end
            end
            DS_DROP: begin
                if (bus.inst_sram_data_ok) begin
                    state_s = DS_IDLE;
                end else begin
                    state_s = DS_DROP;
                end
            end
            default: state_s = DS_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_r    <= DS_IDLE;
            pc_r       <= RESET_PC;
            run_r      <= 1'b0;
            unc_pend_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            run_r      <= 1'b1;
            unc_pend_r <= unc_pend_s;
        end
    end

    assign bus.im_req         = req_s;
    assign bus.im_pc          = pc_r;
    assign bus.I_valid        = ~empty_s;
    assign bus.I_nextNotReady = empty_s;
    assign bus.I_PC           = head_s.pc;
    assign bus.I_Instr        = head_s.instr;

`ifdef FETCH_EXC_TAG_EN
    assign bus.I_inst_miss    = head_s.miss;
    assign bus.I_inst_illegal = head_s.illegal;
    assign bus.I_inst_invalid = head_s.invalid;
    logic unused_full_s;
    assign unused_full_s = full_s;
`else
    assign bus.I_inst_miss    = 1'b0;
    assign bus.I_inst_illegal = 1'b0;
    assign bus.I_inst_invalid = 1'b0;
    logic unused_exc_s;
    assign unused_exc_s = bus.inst_exp_miss ^ bus.inst_exp_illegal ^ bus.inst_exp_invalid ^ full_s;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue (DEPTH=4, RESET_PC=bfc00000).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_instr_fetch_queue;

    localparam logic [31:0] K = 32'h5a5a_0000;
`ifdef FETCH_EXC_TAG_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic Clk;
    logic Clr_n;
    int   pass_cnt;
    int   chk_cnt;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'hbfc0_0000)
    ) dut (
        .Clk   (Clk),
        .Clr_n (Clr_n),
        .bus   (bus)
    );

    // Cached memory model: word is a fixed function of the requested address.
    assign bus.I_icache_rdata = bus.im_pc ^ K;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic set_idle();
        bus.uncache_inst      = 1'b0;
        bus.icache_stall      = 1'b1;
        bus.inst_sram_data_ok = 1'b0;
        bus.Instr_axi_Inter   = 32'h0;
        bus.inst_exp_miss     = 1'b0;
        bus.inst_exp_illegal  = 1'b0;
        bus.inst_exp_invalid  = 1'b0;
        bus.D_redirect        = 1'b0;
        bus.D_NewPC_Pass      = 32'h0;
        bus.exp_flush         = 1'b0;
        bus.exp_pc            = 32'h0;
        bus.D_stall_Pass      = 1'b0;
        bus.dm_stall          = 1'b0;
    endtask

    task automatic test_reset();
        Clr_n = 1'b0;
        set_idle();
        repeat (2) @(negedge Clk);
        chk_cnt++; if (bus.im_req !== 1'b0) $display("FAIL reset_im_req got=%b exp=0", bus.im_req); else pass_cnt++;
        chk_cnt++; if (bus.im_pc !== 32'hbfc0_0000) $display("FAIL reset_im_pc got=%h exp=bfc00000", bus.im_pc); else pass_cnt++;
        chk_cnt++; if (bus.I_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.I_valid); else pass_cnt++;
        chk_cnt++; if (bus.I_PC !== 32'h0 || bus.I_Instr !== 32'h0) $display("FAIL reset_head got=%h/%h exp=0/0", bus.I_PC, bus.I_Instr); else pass_cnt++;
    endtask

    task automatic test_cached_stream();
        Clr_n = 1'b1;
        bus.icache_stall = 1'b0;
        @(negedge Clk);
        chk_cnt++; if (bus.I_valid !== 1'b0) $display("FAIL first_valid_early got=%b exp=0", bus.I_valid); else pass_cnt++;
        chk_cnt++; if (bus.im_req !== 1'b1 || bus.im_pc !== 32'hbfc0_0000) $display("FAIL first_req got=%b/%h exp=1/bfc00000", bus.im_req, bus.im_pc); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            chk_cnt++;
            if (bus.I_valid !== 1'b1 || bus.I_PC !== 32'hbfc0_0000 + 32'(4 * i) || bus.I_Instr !== ((32'hbfc0_0000 + 32'(4 * i)) ^ K))
                $display("FAIL stream_%0d got=%b/%h/%h exp=1/%h/%h", i, bus.I_valid, bus.I_PC, bus.I_Instr,
                         32'hbfc0_0000 + 32'(4 * i), (32'hbfc0_0000 + 32'(4 * i)) ^ K);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall_full();
        bus.D_redirect   = 1'b1;
        bus.D_NewPC_Pass = 32'h0000_1000;
        @(negedge Clk);
        bus.D_redirect   = 1'b0;
        bus.D_stall_Pass = 1'b1;
        chk_cnt++; if (bus.I_valid !== 1'b0) $display("FAIL redirect_empty got=%b exp=0", bus.I_valid); else pass_cnt++;
        repeat (6) @(negedge Clk);
        chk_cnt++; if (bus.im_req !== 1'b0) $display("FAIL full_im_req got=%b exp=0", bus.im_req); else pass_cnt++;
        chk_cnt++; if (bus.im_pc !== 32'h0000_1010) $display("FAIL full_im_pc got=%h exp=00001010", bus.im_pc); else pass_cnt++;
        chk_cnt++; if (bus.I_PC !== 32'h0000_1000 || bus.I_Instr !== (32'h0000_1000 ^ K) || bus.I_nextNotReady !== 1'b0)
            $display("FAIL full_head got=%h/%h/%b exp=00001000/%h/0", bus.I_PC, bus.I_Instr, bus.I_nextNotReady, 32'h0000_1000 ^ K);
        else pass_cnt++;
        bus.D_stall_Pass = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge Clk);
            chk_cnt++;
            if (bus.I_PC !== 32'h0000_1000 + 32'(4 * i))
                $display("FAIL drain_%0d got=%h exp=%h", i, bus.I_PC, 32'h0000_1000 + 32'(4 * i));
            else pass_cnt++;
        end
    endtask

    task automatic test_uncached_redirect();
        bus.D_redirect   = 1'b1;
        bus.D_NewPC_Pass = 32'h0000_2000;
        bus.icache_stall = 1'b1;
        @(negedge Clk);
        bus.D_redirect   = 1'b0;
        bus.uncache_inst = 1'b1;
        @(negedge Clk);
        chk_cnt++; if (bus.im_req !== 1'b1 || bus.im_pc !== 32'h0000_2000) $display("FAIL unc_req got=%b/%h exp=1/00002000", bus.im_req, bus.im_pc); else pass_cnt++;
        bus.D_redirect   = 1'b1;
        bus.D_NewPC_Pass = 32'h8000_1000;
        @(negedge Clk);
        bus.D_redirect        = 1'b0;
        bus.inst_sram_data_ok = 1'b1;
        bus.Instr_axi_Inter   = 32'hdead_beef;
        chk_cnt++; if (bus.im_req !== 1'b0) $display("FAIL drop_im_req got=%b exp=0", bus.im_req); else pass_cnt++;
        @(negedge Clk);
        chk_cnt++; if (bus.I_valid !== 1'b0) $display("FAIL late_data_dropped got=%b exp=0", bus.I_valid); else pass_cnt++;
        chk_cnt++; if (bus.im_req !== 1'b1 || bus.im_pc !== 32'h8000_1000) $display("FAIL post_drop_req got=%b/%h exp=1/80001000", bus.im_req, bus.im_pc); else pass_cnt++;
        bus.Instr_axi_Inter = 32'h1111_2222;
        @(negedge Clk);
        bus.inst_sram_data_ok = 1'b0;
        chk_cnt++; if (bus.I_valid !== 1'b1 || bus.I_PC !== 32'h8000_1000 || bus.I_Instr !== 32'h1111_2222)
            $display("FAIL redirect_head got=%b/%h/%h exp=1/80001000/11112222", bus.I_valid, bus.I_PC, bus.I_Instr);
        else pass_cnt++;
    endtask

    task automatic test_flush_priority();
        bus.uncache_inst = 1'b0;
        bus.icache_stall = 1'b0;
        @(negedge Clk);
        chk_cnt++; if (bus.I_valid !== 1'b1) $display("FAIL preflush_valid got=%b exp=1", bus.I_valid); else pass_cnt++;
        bus.exp_flush    = 1'b1;
        bus.exp_pc       = 32'hbfc0_0380;
        bus.D_redirect   = 1'b1;
        bus.D_NewPC_Pass = 32'h1234_0000;
        #1;
        chk_cnt++; if (bus.im_req !== 1'b0) $display("FAIL flush_im_req got=%b exp=0", bus.im_req); else pass_cnt++;
        @(negedge Clk);
        bus.exp_flush  = 1'b0;
        bus.D_redirect = 1'b0;
        chk_cnt++; if (bus.I_valid !== 1'b0 || bus.im_pc !== 32'hbfc0_0380) $display("FAIL flush_state got=%b/%h exp=0/bfc00380", bus.I_valid, bus.im_pc); else pass_cnt++;
        @(negedge Clk);
        chk_cnt++; if (bus.I_PC !== 32'hbfc0_0380) $display("FAIL flush_head got=%h exp=bfc00380", bus.I_PC); else pass_cnt++;
    endtask

    task automatic test_exc_wrap();
        bus.D_redirect   = 1'b1;
        bus.D_NewPC_Pass = 32'hffff_fffc;
        bus.icache_stall = 1'b1;
        @(negedge Clk);
        bus.D_redirect       = 1'b0;
        bus.D_stall_Pass     = 1'b1;
        bus.icache_stall     = 1'b0;
        bus.inst_exp_illegal = 1'b1;
        @(negedge Clk);
        bus.inst_exp_illegal = 1'b0;
        chk_cnt++; if (bus.I_PC !== 32'hffff_fffc) $display("FAIL exc_pc got=%h exp=fffffffc", bus.I_PC); else pass_cnt++;
        chk_cnt++; if (bus.I_inst_illegal !== EXC_EN) $display("FAIL exc_flag got=%b exp=%b", bus.I_inst_illegal, EXC_EN); else pass_cnt++;
        chk_cnt++; if (bus.I_Instr !== (EXC_EN ? 32'h0 : (32'hffff_fffc ^ K))) $display("FAIL exc_word got=%h exp=%h", bus.I_Instr, EXC_EN ? 32'h0 : (32'hffff_fffc ^ K)); else pass_cnt++;
        @(negedge Clk);
        bus.icache_stall = 1'b1;
        chk_cnt++; if (bus.im_pc !== 32'h0000_0004) $display("FAIL wrap_im_pc got=%h exp=00000004", bus.im_pc); else pass_cnt++;
        bus.D_stall_Pass = 1'b0;
        @(negedge Clk);
        chk_cnt++; if (bus.I_PC !== 32'h0 || bus.I_Instr !== K || bus.I_inst_illegal !== 1'b0)
            $display("FAIL wrap_head got=%h/%h/%b exp=00000000/%h/0", bus.I_PC, bus.I_Instr, bus.I_inst_illegal, K);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.D_stall_Pass = 1'b1;
        bus.icache_stall = 1'b0;
        @(negedge Clk);
        bus.icache_stall = 1'b1;
        bus.uncache_inst = 1'b1;
        @(negedge Clk);
        chk_cnt++; if (bus.I_valid !== 1'b1 || bus.im_req !== 1'b1) $display("FAIL premid_state got=%b/%b exp=1/1", bus.I_valid, bus.im_req); else pass_cnt++;
        Clr_n = 1'b0;
        #1;
        chk_cnt++; if (bus.I_valid !== 1'b0 || bus.im_req !== 1'b0 || bus.im_pc !== 32'hbfc0_0000)
            $display("FAIL midreset got=%b/%b/%h exp=0/0/bfc00000", bus.I_valid, bus.im_req, bus.im_pc);
        else pass_cnt++;
        @(negedge Clk);
        Clr_n                 = 1'b1;
        bus.inst_sram_data_ok = 1'b1;
        bus.Instr_axi_Inter   = 32'hcafe_f00d;
        @(negedge Clk);
        bus.inst_sram_data_ok = 1'b0;
        chk_cnt++; if (bus.I_valid !== 1'b0) $display("FAIL stray_ok_ignored got=%b exp=0", bus.I_valid); else pass_cnt++;
        chk_cnt++; if (bus.im_req !== 1'b1 || bus.im_pc !== 32'hbfc0_0000) $display("FAIL post_reset_req got=%b/%h exp=1/bfc00000", bus.im_req, bus.im_pc); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        test_reset();
        test_cached_stream();
        test_stall_full();
        test_uncached_redirect();
        test_flush_priority();
        test_exc_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
